// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory sequencer: request/grant bus,
// pipeline stall, load lane extraction and misalign/timeout reporting.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable_in,
  input  logic        mem_rw_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall_out,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        legal;
  logic        aligned;
  logic        start;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        timed_out;

  // Unsigned loads are only legal as loads; stores stop at SW.
  always_comb begin
    legal = 1'b0;
    case (funct3_in)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = mem_rw_in;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3_in[1:0])
      2'b01:   aligned = ~addr_in[0];
      2'b10:   aligned = (addr_in[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign start = (state == S_IDLE) & mem_enable_in & legal & aligned;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_in;
    case (funct3_in[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_in[1:0];
        wdata_c = {4{store_in[7:0]}};
      end
      2'b01: begin
        be_c    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_in[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_in;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then extend by the captured funct3.
  always_comb begin
    rd_shift = bus_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = bus_rdata;
    endcase
  end

  assign timed_out = (cnt == TIMEOUT_C);

  assign bus_req   = (state == S_REQ);
  assign stall_out = reset & (start | (state == S_REQ) | (state == S_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_wdata    <= 32'd0;
      bus_be       <= 4'd0;
      load_data    <= 32'd0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus_addr  <= {addr_in[31:2], 2'b00};
            bus_we    <= ~mem_rw_in;
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            funct3_q  <= funct3_in;
            lane_q    <= addr_in[1:0];
            cnt       <= 8'd0;
            state     <= S_REQ;
          end else if (mem_enable_in) begin
            misalign_err <= 1'b1;
          end
        end
        S_REQ: begin
          cnt <= cnt + 8'd1;
          if (bus_gnt && (bus_we || bus_rvalid)) begin
            load_valid <= 1'b1;
            load_data  <= bus_we ? 32'd0 : rd_ext;
            state      <= S_DONE;
          end else if (timed_out) begin
            // A read granted in the timeout cycle without data is still aborted.
            bus_err   <= 1'b1;
            load_data <= 32'd0;
            state     <= S_DONE;
          end else if (bus_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (bus_rvalid) begin
            load_valid <= 1'b1;
            load_data  <= rd_ext;
            state      <= S_DONE;
          end else if (timed_out) begin
            bus_err   <= 1'b1;
            load_data <= 32'd0;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for the MEM stage's data-memory port. It takes the access decoded into the EX/MEM pipeline register and drives a request/grant/valid data bus. It stalls the pipeline while the access is in flight, then returns byte-lane-aligned, sign- or zero-extended load data to the writeback path. It sits between the EX/MEM register outputs and the MEM/WB register inputs, and it also flags misaligned or illegal accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT, default 15: maximum cycles spent in REQ+WAIT before the access is aborted. Legal range is 1–255.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- mem_enable_in, input, 1: the MEM-stage instruction accesses memory.
- mem_rw_in, input, 1: 1 = load, 0 = store.
- funct3_in, input, 3: RV32I load/store funct3.
- addr_in, input, 32: effective address (ALU result).
- store_in, input, 32: store data, taken from rs2.
- bus_req, output, 1: bus request, held until bus_gnt.
- bus_we, output, 1: 1 = write.
- bus_addr, output, 32: word-aligned address, {addr_in[31:2],2'b00}.
- bus_wdata, output, 32: lane-replicated store data.
- bus_be, output, 4: byte enables.
- bus_gnt, input, 1: request accepted this cycle.
- bus_rvalid, input, 1: bus_rdata valid this cycle.
- bus_rdata, input, 32: read word.
- stall_out, output, 1: freeze PC, IF/ID, ID/EX and EX/MEM registers.
- load_data, output, 32: extended load result.
- load_valid, output, 1: one-cycle pulse; load_data is valid.
- misalign_err, output, 1: one-cycle pulse; misaligned or illegal access, no bus cycle issued.
- bus_err, output, 1: one-cycle pulse; access aborted by timeout.

## Operation
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **start:** start = mem_enable_in & legal & aligned, evaluated in IDLE only.
- **Legal funct3 values:**
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- **Alignment:**
  - Halfword access requires addr_in[0]=0.
  - Word access requires addr_in[1:0]=00.
- **IDLE, on start:**
  - Capture bus_addr, bus_we = ~mem_rw_in, bus_be, bus_wdata, funct3 and addr_in[1:0].
  - Go to REQ.
- **IDLE, on mem_enable_in with an illegal or misaligned access:**
  - Pulse misalign_err next cycle.
  - Remain in IDLE, no stall.
- **REQ:**
  - bus_req=1.
  - On bus_gnt: a write goes to DONE; a read goes to WAIT.
  - If bus_rvalid arrives in the same cycle as bus_gnt, a read goes directly to DONE.
- **WAIT:** on bus_rvalid, register the extended data and go to DONE.
- **DONE:**
  - load_valid=1 for a load, and also for a store.
  - stall_out=0.
  - Next state is always IDLE. No new start is accepted in DONE.
- **Byte enables and write data:**
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{store_in[7:0]}}.
  - SH: be = 0011 or 1100 (selected by addr[1]), wdata = {2{store_in[15:0]}}.
  - SW: be = 1111, wdata = store_in.
- **Load extraction:**
  - Select the byte or halfword by the captured addr[1:0].
  - LB and LH sign-extend from bit 7 or 15; LBU and LHU zero-extend.
- **Timeout:**
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the counter equals TIMEOUT with no completion that cycle, go to DONE with bus_err=1, load_data=0 and load_valid=0.
- **Reset behaviour:**
  - Reset asserted, at any time: state=IDLE immediately. bus_req, bus_we, bus_addr, bus_wdata, bus_be, load_data, load_valid, misalign_err and bus_err all read 0. The counter is cleared.
  - While reset is low, stall_out is forced to 0.

## Timing
- stall_out = (IDLE & start) | REQ | WAIT. It is combinational from inputs in IDLE, so the EX/MEM register holds in the start cycle.
- **Store, gnt at first chance:**
  - Cycle 0: start, stall=1.
  - Cycle 1: REQ, gnt, stall=1.
  - Cycle 2: DONE, stall=0.
  - Total: 2 stall cycles.
- **Load, gnt in cycle 1 and rvalid in cycle 2:**
  - Cycle 3: DONE with load_valid and data.
  - Total: 3 stall cycles.
- bus_req stays high through REQ until bus_gnt is sampled. Address, data and enables are stable while bus_req=1.
- A bus_rvalid arriving outside WAIT (or outside the REQ+gnt case) is ignored.
- After DONE there is one IDLE cycle minimum between accesses, because start is evaluated in IDLE only.
- The timeout produces DONE in cycle TIMEOUT+1 after REQ entry (REQ entry = cycle 1 relative to start).

## Test plan
- **SW:** addr=0x100, store_in=0xDEADBEEF, gnt in first REQ cycle → bus_be=1111, bus_addr=0x100, bus_we=1, stall high for 2 cycles, DONE in cycle 2.
- **SB:** addr=0x103, store_in=0x000000A5 → bus_be=1000, bus_wdata=0xA5A5A5A5.
- **Loads** with bus_rdata=0x80FF7F01, rvalid 3 cycles after gnt:
  - LB at addr=0x202 → load_data=0xFFFFFFFF.
  - LBU at addr=0x200 → load_data=0x00000001.
  - LH at addr=0x202 → load_data=0xFFFF80FF.
  - LHU at addr=0x200 → load_data=0x00007F01.
- **Misaligned and illegal:**
  - LW at addr=0x201 → misalign_err pulse, no bus_req, stall never asserted.
  - funct3=011 → misalign_err pulse.
- **Timeout:** TIMEOUT=4, gnt never asserted → bus_err pulse, stall released, load_valid=0.
- **Reset mid-access:** reset driven low while in WAIT → bus_req, stall_out and load_valid are 0 immediately (before the next clk edge). After reset is released with mem_enable_in=0, the block stays IDLE.
